// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_buffer_ctrl
// Purpose  : Character buffer, cursor and writer arbitration for the text
//            renderer. Optional cursor blink with `define CURSOR_BLINK_EN.
// Revision : 1.0  initial release
// ============================================================================
module text_buffer_ctrl #(
    parameter int NCHARS     = 64,
    parameter int ADDR_W     = 8,
    parameter int BLINK_BITS = 24
) (
    input  logic              iVGA_CLK,
    input  logic              iRST,
    input  logic              kb_req,
    input  logic [7:0]        kb_char,
    output logic              kb_ack,
    input  logic              host_req,
    input  logic [7:0]        host_char,
    output logic              host_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy,
    output logic              full,
    output logic              cursor_vis
);

    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(NCHARS - 1);
    localparam logic [ADDR_W-1:0] c_DEPTH   = ADDR_W'(NCHARS);
    localparam logic [ADDR_W-1:0] c_ONE     = ADDR_W'(1);
    localparam logic [7:0]        c_BAR     = 8'h7C;
    localparam logic [7:0]        c_CMD_CLR = 8'd1;
    localparam logic [7:0]        c_CMD_BS  = 8'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cursor;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_prio;
    logic [7:0]        r_cmd;
    logic              r_kb_ack;
    logic              r_host_ack;
    logic [7:0]        r_rd_data;
    logic [7:0]        r_mem [0:NCHARS-1];

    logic              w_pick_host;
    logic              w_do_bs;
    logic              w_do_wr;
    logic              w_clr_done;
    logic              w_we0;
    logic              w_we1;
    logic [ADDR_W-1:0] w_addr0;
    logic [ADDR_W-1:0] w_addr1;
    logic [7:0]        w_data0;
    logic [7:0]        w_data1;
    logic [7:0]        w_rd_byte;

    function automatic logic f_is_print(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) ||
               ((c >= 8'h61) && (c <= 8'h7A)) ||
               ((c >= 8'h30) && (c <= 8'h39)) ||
               (c == 8'h3D) || (c == 8'h7C) || (c == 8'h2D);
    endfunction

    // prio=1 favours the host when both sides request together
    assign w_pick_host = host_req && (!kb_req || r_prio);
    assign w_do_bs     = (r_state == S_EXEC) && (r_cmd == c_CMD_BS) && (r_cursor != '0);
    assign w_do_wr     = (r_state == S_EXEC) && f_is_print(r_cmd) && (r_cursor < c_LAST);
    assign w_clr_done  = (r_state == S_CLEAR) && (r_clr_idx == c_DEPTH);

    assign kb_ack   = r_kb_ack;
    assign host_ack = r_host_ack;
    assign rd_data  = r_rd_data;
    assign cursor   = r_cursor;
    assign busy     = (r_state == S_CLEAR);
    assign full     = (r_cursor == c_LAST);

    always_comb begin
        w_we0   = 1'b0;
        w_we1   = 1'b0;
        w_addr0 = '0;
        w_addr1 = '0;
        w_data0 = 8'h00;
        w_data1 = 8'h00;
        if (r_state == S_CLEAR) begin
            w_we0 = 1'b1;
            if (w_clr_done) begin
                w_data0 = c_BAR;
            end else begin
                w_addr0 = r_clr_idx;
            end
        end else if (w_do_bs) begin
            w_we0   = 1'b1;
            w_addr0 = r_cursor - c_ONE;
            w_data0 = c_BAR;
            w_we1   = 1'b1;
            w_addr1 = r_cursor;
        end else if (w_do_wr) begin
            w_we0   = 1'b1;
            w_addr0 = r_cursor;
            w_data0 = r_cmd;
            w_we1   = 1'b1;
            w_addr1 = r_cursor + c_ONE;
            w_data1 = c_BAR;
        end
    end

    // Storage is deliberately unreset; the CLEAR pass after reset wipes it
    always_ff @(posedge iVGA_CLK) begin
        for (int i = 0; i < NCHARS; i++) begin
            if (w_we0 && (w_addr0 == ADDR_W'(i))) begin
                r_mem[i] <= w_data0;
            end else if (w_we1 && (w_addr1 == ADDR_W'(i))) begin
                r_mem[i] <= w_data1;
            end
        end
    end

    always_comb begin
        w_rd_byte = 8'h00;
        for (int i = 0; i < NCHARS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                w_rd_byte = r_mem[i];
            end
        end
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= w_rd_byte;
        end
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_state    <= S_CLEAR;
            r_clr_idx  <= '0;
            r_cursor   <= '0;
            r_prio     <= 1'b0;
            r_cmd      <= 8'h00;
            r_kb_ack   <= 1'b0;
            r_host_ack <= 1'b0;
        end else begin
            r_kb_ack   <= 1'b0;
            r_host_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (kb_req || host_req) begin
                        r_cmd      <= w_pick_host ? host_char : kb_char;
                        r_host_ack <= w_pick_host;
                        r_kb_ack   <= !w_pick_host;
                        if (kb_req && host_req) begin
                            r_prio <= ~r_prio;
                        end
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    if (r_cmd == c_CMD_CLR) begin
                        r_clr_idx <= '0;
                        r_state   <= S_CLEAR;
                    end else if (w_do_bs) begin
                        r_cursor <= r_cursor - c_ONE;
                    end else if (w_do_wr) begin
                        r_cursor <= r_cursor + c_ONE;
                    end
                end
                S_CLEAR: begin
                    if (w_clr_done) begin
                        r_cursor <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_clr_idx <= r_clr_idx + c_ONE;
                    end
                end
                default: begin
                    r_clr_idx <= '0;
                    r_state   <= S_CLEAR;
                end
            endcase
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [BLINK_BITS-1:0] r_blink_cnt;
    logic                  w_blink_rst;

    assign w_blink_rst = w_do_wr || w_do_bs || w_clr_done;

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_blink_cnt <= '0;
        end else if (w_blink_rst) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_BITS'(1);
        end
    end

    assign cursor_vis = ~r_blink_cnt[BLINK_BITS-1];
`else
    // Without the blink counter any legal BLINK_BITS leaves the cursor always shown
    assign cursor_vis = (BLINK_BITS > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_buffer_ctrl
// Purpose  : Self-checking bench for text_buffer_ctrl against a buffer model.
// Revision : 1.0  initial release
// ============================================================================
module tb_text_buffer_ctrl;

    localparam int NCHARS = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              kb_req = 1'b0;
    logic [7:0]        kb_char = 8'h00;
    logic              kb_ack;
    logic              host_req = 1'b0;
    logic [7:0]        host_char = 8'h00;
    logic              host_ack;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] cursor;
    logic              busy;
    logic              full;
    logic              cursor_vis;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  mdl_mem [NCHARS];
    int          mdl_cur  = 0;
    bit          mdl_prio = 1'b0;
    string       print_set = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789=|-";

    always #5 clk = ~clk;

    text_buffer_ctrl #(
        .NCHARS     (NCHARS),
        .ADDR_W     (ADDR_W),
        .BLINK_BITS (24)
    ) dut (
        .iVGA_CLK   (clk),
        .iRST       (rst),
        .kb_req     (kb_req),
        .kb_char    (kb_char),
        .kb_ack     (kb_ack),
        .host_req   (host_req),
        .host_char  (host_char),
        .host_ack   (host_ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cursor     (cursor),
        .busy       (busy),
        .full       (full),
        .cursor_vis (cursor_vis)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_print(input logic [7:0] c);
        for (int i = 0; i < print_set.len(); i++) begin
            if (c == print_set[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] rand_print();
        return print_set[$urandom_range(0, print_set.len() - 1)];
    endfunction

    function automatic logic [7:0] rand_invalid();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255));
        while (is_print(c) || c == 8'd1 || c == 8'd8);
        return c;
    endfunction

    task automatic model_wipe();
        for (int i = 0; i < NCHARS; i++) mdl_mem[i] = 8'h00;
        mdl_mem[0] = 8'h7C;
        mdl_cur    = 0;
    endtask

    task automatic model_apply(input logic [7:0] c);
        if (c == 8'd1) begin
            model_wipe();
        end else if (c == 8'd8) begin
            if (mdl_cur > 0) begin
                mdl_mem[mdl_cur-1] = 8'h7C;
                mdl_mem[mdl_cur]   = 8'h00;
                mdl_cur--;
            end
        end else if (is_print(c) && mdl_cur < NCHARS - 1) begin
            mdl_mem[mdl_cur]   = c;
            mdl_mem[mdl_cur+1] = 8'h7C;
            mdl_cur++;
        end
    endtask

    function automatic logic [7:0] rd_expect(input int a);
        if (a < NCHARS) return mdl_mem[a];
        return 8'h00;
    endfunction

    task automatic rd_check(input int a);
        rd_addr = ADDR_W'(a);
        tick();
        check($sformatf("rd[%0d]", a), rd_data, rd_expect(a));
    endtask

    task automatic state_check(input string tag);
        check({tag, "_cursor"}, cursor, mdl_cur);
        check({tag, "_full"}, full, (mdl_cur == NCHARS - 1));
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy && n < 4 * NCHARS) begin
            tick();
            n++;
        end
        check(tag, n, NCHARS + 1);
    endtask

    task automatic send(input bit use_host, input logic [7:0] c);
        int n   = 0;
        bit got = 1'b0;
        if (use_host) begin host_char = c; host_req = 1'b1; end
        else          begin kb_char   = c; kb_req   = 1'b1; end
        while (!got && n < 50) begin
            tick();
            n++;
            got = use_host ? host_ack : kb_ack;
        end
        kb_req   = 1'b0;
        host_req = 1'b0;
        check("ack_seen", got, 1);
        if (got) begin
            check("other_ack_quiet", use_host ? kb_ack : host_ack, 0);
            tick();
            check("ack_pulse", use_host ? host_ack : kb_ack, 0);
            if (c == 8'd1) wait_clear("clear_cmd_busy");
            model_apply(c);
        end
    endtask

    task automatic send_both(input logic [7:0] ck, input logic [7:0] ch);
        int n = 0;
        bit first_host;
        kb_char = ck; host_char = ch;
        kb_req  = 1'b1; host_req = 1'b1;
        while (!(kb_ack || host_ack) && n < 50) begin
            tick();
            n++;
        end
        check("arb_first_seen", kb_ack || host_ack, 1);
        first_host = host_ack;
        check("arb_first_side", first_host, mdl_prio);
        if (first_host) host_req = 1'b0; else kb_req = 1'b0;
        n = 0;
        while (!(first_host ? kb_ack : host_ack) && n < 50) begin
            tick();
            n++;
        end
        kb_req = 1'b0; host_req = 1'b0;
        check("arb_gap", n, 2);
        tick();
        model_apply(first_host ? ch : ck);
        model_apply(first_host ? ck : ch);
        mdl_prio = ~mdl_prio;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   r;
        bit   early;
        // reset and the wiping pass that follows it
        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_kb_ack", kb_ack, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_cursor", cursor, 0);
        rst = 1'b0;
        wait_clear("reset_busy");
        model_wipe();
        mdl_prio = 1'b0;
        state_check("after_reset");
`ifndef CURSOR_BLINK_EN
        check("cursor_vis", cursor_vis, 1);
`endif
        for (int a = 0; a < (1 << ADDR_W); a++) rd_check(a);

        send(1'b0, "A"); send(1'b0, "b"); send(1'b0, "7");
        state_check("typed3");
        for (int a = 0; a < 4; a++) rd_check(a);

        send_both("X", "Y");
        send_both("X", "Y");
        state_check("arb");
        for (int a = 0; a < NCHARS; a++) rd_check(a);

        send(1'b0, 8'd1);
        send(1'b1, "Q"); send(1'b0, "R"); send(1'b0, 8'd8);
        state_check("bs1");
        rd_check(1); rd_check(2);
        send(1'b0, 8'd8); send(1'b1, 8'd8);
        state_check("bs_at_zero");
        rd_check(0); rd_check(1);
        send(1'b0, "#");
        state_check("invalid");

        send(1'b1, 8'd1);
        repeat (7) send(1'b0, "Z");
        state_check("fill");
        send(1'b0, "Z");
        state_check("overflow");
        for (int a = 0; a < NCHARS; a++) rd_check(a);
        send(1'b1, 8'd1);
        state_check("cleared");

        // reset pulsed while CLEAR is at index 3, with a host request pending
        kb_char = 8'd1; kb_req = 1'b1;
        n = 0;
        while (!kb_ack && n < 50) begin tick(); n++; end
        kb_req = 1'b0;
        check("clr_ack_seen", kb_ack, 1);
        repeat (4) tick();
        host_char = "H"; host_req = 1'b1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_wipe();
        mdl_prio = 1'b0;
        n = 0;
        early = 1'b0;
        while (busy && n < 4 * NCHARS) begin
            tick();
            n++;
            if (host_ack && busy) early = 1'b1;
        end
        check("rst_mid_clear_busy", n, NCHARS + 1);
        check("no_ack_while_busy", early, 0);
        n = 0;
        while (!host_ack && n < 50) begin tick(); n++; end
        host_req = 1'b0;
        check("pending_ack_latency", n, 1);
        tick();
        model_apply("H");
        state_check("after_rst_mid_clear");
        rd_check(0); rd_check(1);

        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      send(1'($urandom_range(0, 1)), rand_print());
            else if (r < 60) send_both(rand_print(), rand_print());
            else if (r < 75) send(1'($urandom_range(0, 1)), 8'd8);
            else if (r < 90) send(1'($urandom_range(0, 1)), rand_invalid());
            else if (r < 94) send(1'($urandom_range(0, 1)), 8'd1);
            state_check("rand");
            rd_check($urandom_range(0, (1 << ADDR_W) - 1));
            rd_check(mdl_cur);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
